// File: rtl/m_epp_fifo.sv
// Buffered bridge between the midgetv bus and the single-byte EPP port block.
// Define M_EPP_FIFO_COUNT_EN for FIFO occupancy readback and flush on ADR 2/3.
module m_epp_fifo #(
  parameter int RXLOG2 = 3,
  parameter int TXLOG2 = 3,
  parameter int GAPCYC = 2
) (
  input  logic       CLK_I,
  input  logic       nRST_I,
  input  logic [7:0] DAT_I,
  input  logic [1:0] ADR_I,
  input  logic       STB_I,
  input  logic       WE_I,
  output logic [7:0] DAT_O,
  output logic       ACK_O,
  output logic       M_STB_O,
  output logic       M_WE_O,
  output logic       M_ADR_O,
  output logic [7:0] M_DAT_O,
  input  logic [7:0] M_DAT_I,
  input  logic       M_ACK_I
);

  typedef enum logic [2:0] {
    POLL   = 3'd0,
    DECIDE = 3'd1,
    RD     = 3'd2,
    WR     = 3'd3,
    GAP    = 3'd4
  } state_t;

  localparam int RXD = 2 ** RXLOG2;
  localparam int TXD = 2 ** TXLOG2;
  localparam logic [3:0] GAP_LAST = 4'(GAPCYC - 1);
  localparam logic [RXLOG2:0] RX_INC = {{RXLOG2{1'b0}}, 1'b1};
  localparam logic [TXLOG2:0] TX_INC = {{TXLOG2{1'b0}}, 1'b1};

  state_t state, state_nxt;
  logic [3:0] gap_cnt, gap_nxt;
  logic [1:0] stat;
  logic       last_rd;
  logic       m_stb, m_we, m_adr;
  logic       urn, drp;

  logic [7:0]      rx_mem [0:RXD-1];
  logic [7:0]      tx_mem [0:TXD-1];
  logic [RXLOG2:0] rx_wp, rx_rp;
  logic [TXLOG2:0] tx_wp, tx_rp;
  logic            rx_empty, rx_full, tx_empty, tx_full;

  logic rd_acc, wr_acc, port_ack;
  logic rx_push, rx_pop, tx_push, tx_pop, rx_flush, tx_flush;
  logic urn_set, drp_set, urn_clr, drp_clr;
  logic rd_ok, wr_ok;
  logic [7:0] rdata;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RXLOG2] != rx_rp[RXLOG2]) &&
                    (rx_wp[RXLOG2-1:0] == rx_rp[RXLOG2-1:0]);
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TXLOG2] != tx_rp[TXLOG2]) &&
                    (tx_wp[TXLOG2-1:0] == tx_rp[TXLOG2-1:0]);

  assign rd_acc   = STB_I & ~WE_I;
  assign wr_acc   = STB_I & WE_I;
  assign port_ack = m_stb & M_ACK_I;

  assign rx_pop  = rd_acc && (ADR_I == 2'd0) && !rx_empty;
  assign urn_set = rd_acc && (ADR_I == 2'd0) && rx_empty;
  assign tx_push = wr_acc && (ADR_I == 2'd0) && !tx_full;
  assign drp_set = wr_acc && (ADR_I == 2'd0) && tx_full;
  assign urn_clr = wr_acc && (ADR_I == 2'd1) && DAT_I[2];
  assign drp_clr = wr_acc && (ADR_I == 2'd1) && DAT_I[3];
  assign rx_push = (state == RD) && port_ack;
  assign tx_pop  = (state == WR) && port_ack;

  // DECIDE only trusts stat as sampled by the last POLL.
  assign rd_ok = stat[1] && !rx_full;
  assign wr_ok = !stat[0] && !tx_empty;

`ifdef M_EPP_FIFO_COUNT_EN
  logic [RXLOG2:0] rx_cnt;
  logic [TXLOG2:0] tx_cnt;
  assign rx_cnt   = rx_wp - rx_rp;
  assign tx_cnt   = tx_wp - tx_rp;
  assign rx_flush = wr_acc && (ADR_I == 2'd2);
  assign tx_flush = wr_acc && (ADR_I == 2'd3);
`else
  assign rx_flush = 1'b0;
  assign tx_flush = 1'b0;
`endif

  // Port-side master: next state and gap counting.
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    case (state)
      POLL: begin
        if (port_ack) state_nxt = DECIDE;
        else          state_nxt = POLL;
      end
      DECIDE: begin
        // RX has priority unless it won the previous data access and TX also waits.
        if (rd_ok && (!wr_ok || !last_rd)) state_nxt = RD;
        else if (wr_ok)                    state_nxt = WR;
        else                               state_nxt = POLL;
      end
      RD, WR: begin
        if (port_ack) state_nxt = GAP;
        else          state_nxt = state;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = POLL;
          gap_nxt   = 4'd0;
        end else begin
          state_nxt = GAP;
          gap_nxt   = gap_cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = POLL;
        gap_nxt   = 4'd0;
      end
    endcase
  end

  // State, registered port strobes and sampled status.
  always_ff @(posedge CLK_I) begin
    if (!nRST_I) begin
      state   <= POLL;
      gap_cnt <= 4'd0;
      m_stb   <= 1'b0;
      m_we    <= 1'b0;
      m_adr   <= 1'b1;
      stat    <= 2'b00;
      last_rd <= 1'b0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
      m_stb   <= (state_nxt == POLL) || (state_nxt == RD) || (state_nxt == WR);
      m_we    <= (state_nxt == WR);
      m_adr   <= !((state_nxt == RD) || (state_nxt == WR));
      if ((state == POLL) && port_ack) stat <= M_DAT_I[1:0];
      if (rx_push)     last_rd <= 1'b1;
      else if (tx_pop) last_rd <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge CLK_I) begin
    if (rx_push) rx_mem[rx_wp[RXLOG2-1:0]] <= M_DAT_I;
    if (tx_push) tx_mem[tx_wp[TXLOG2-1:0]] <= DAT_I;
  end

  // FIFO pointers; a flush equalises read to write pointer.
  always_ff @(posedge CLK_I) begin
    if (!nRST_I) begin
      rx_wp <= '0;
      rx_rp <= '0;
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (rx_push)     rx_wp <= rx_wp + RX_INC;
      if (rx_flush)    rx_rp <= rx_wp;
      else if (rx_pop) rx_rp <= rx_rp + RX_INC;
      if (tx_push)     tx_wp <= tx_wp + TX_INC;
      if (tx_flush)    tx_rp <= tx_wp;
      else if (tx_pop) tx_rp <= tx_rp + TX_INC;
    end
  end

  // Sticky underrun / drop flags.
  always_ff @(posedge CLK_I) begin
    if (!nRST_I) begin
      urn <= 1'b0;
      drp <= 1'b0;
    end else begin
      if (urn_set)      urn <= 1'b1;
      else if (urn_clr) urn <= 1'b0;
      if (drp_set)      drp <= 1'b1;
      else if (drp_clr) drp <= 1'b0;
    end
  end

  // midgetv read mux.
  always_comb begin
    rdata = 8'h00;
    if (STB_I) begin
      case (ADR_I)
        2'd0: begin
          if (rx_empty) rdata = 8'h00;
          else          rdata = rx_mem[rx_rp[RXLOG2-1:0]];
        end
        2'd1: rdata = {4'b0000, drp, urn, tx_full, ~rx_empty};
`ifdef M_EPP_FIFO_COUNT_EN
        2'd2: rdata = 8'(rx_cnt);
        2'd3: rdata = 8'(tx_cnt);
`endif
        default: rdata = 8'h00;
      endcase
    end else begin
      rdata = 8'h00;
    end
  end

  assign DAT_O   = rdata;
  assign ACK_O   = STB_I;
  assign M_STB_O = m_stb;
  assign M_WE_O  = m_we;
  assign M_ADR_O = m_adr;
  assign M_DAT_O = tx_mem[tx_rp[TXLOG2-1:0]];

endmodule

// File: tb/tb_m_epp_fifo.sv
// Directed bench for m_epp_fifo with a behavioural EPP port and byte scoreboards.
// Build with M_EPP_FIFO_COUNT_EN defined to cover the occupancy registers.
`timescale 1ns/1ps
module tb_m_epp_fifo;
  localparam int GAPCYC = 2;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst, stb_i, we_i, ack_o;
  logic [1:0] adr_i;
  logic [7:0] dat_i, dat_o;
  logic       m_stb, m_we, m_adr, m_ack;
  logic [7:0] m_dat_o, m_dat_i;

  logic       data_ack_en = 1'b1;
  logic       tx_busy = 1'b0;
  logic       port_has = 1'b0;
  logic [7:0] port_head = 8'h00;
  logic       pop_port = 1'b0;
  logic [7:0] port_q[$];
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];
  int         acc_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, last_poll = 0, poll_gap = 0, last_wr = 0, wr_gap = 0, wr_count = 0;

  assign m_ack   = m_stb & (m_adr | data_ack_en);
  assign m_dat_i = m_adr ? {6'b000000, port_has, tx_busy} : port_head;

  m_epp_fifo #(.RXLOG2(3), .TXLOG2(3), .GAPCYC(GAPCYC)) dut (
    .CLK_I(clk), .nRST_I(nrst), .DAT_I(dat_i), .ADR_I(adr_i), .STB_I(stb_i),
    .WE_I(we_i), .DAT_O(dat_o), .ACK_O(ack_o), .M_STB_O(m_stb), .M_WE_O(m_we),
    .M_ADR_O(m_adr), .M_DAT_O(m_dat_o), .M_DAT_I(m_dat_i), .M_ACK_I(m_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void port_refresh();
    port_has  = (port_q.size() != 0);
    port_head = port_has ? port_q[0] : 8'h00;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Port model and scoreboard side: record accesses, pop TX expectations on writes.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (pop_port) begin
      pop_port = 1'b0;
      if (port_q.size() != 0) port_q.delete(0);
      port_refresh();
    end
    if (m_stb && m_ack) begin
      if (m_adr) begin
        poll_gap  = cyc - last_poll;
        last_poll = cyc;
      end else if (m_we) begin
        acc_q.push_back(1);
        wr_gap  = cyc - last_wr;
        last_wr = cyc;
        wr_count++;
        exp = (tx_exp.size() != 0) ? {24'h0, tx_exp.pop_front()} : 32'h100;
        check("tx_byte", {24'h0, m_dat_o}, exp);
      end else begin
        acc_q.push_back(0);
        if (nrst) rx_exp.push_back(port_head);
        pop_port = 1'b1;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d;
    @(posedge clk); #1;
    stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    stb_i = 1'b1; we_i = 1'b0; adr_i = a;
    #1 d = dat_o;
    @(posedge clk); #1;
    stb_i = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(tag, {24'h0, d}, {24'h0, exp});
  endtask

  initial begin
    logic [7:0]  d;
    logic [31:0] exp;
    int n, w0;
    nrst = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = 2'd0; dat_i = 8'h00;
    wait_cyc(3);
    check("reset_port_outs", {29'h0, m_stb, m_adr, m_we}, 32'h2);
    check("dat_o_idle", {24'h0, dat_o}, 32'h0);
    nrst = 1'b1;

    // A byte waits at the port but data accesses are not acked: RD must hold.
    data_ack_en = 1'b0;
    port_q.push_back(8'h11); port_refresh();
    n = 0;
    do begin wait_cyc(1); n++; end while (!(m_stb && !m_adr && !m_we) && n < 40);
    check("rd_strobe", {29'h0, m_stb, m_adr, m_we}, 32'h4);
    wait_cyc(3);
    check("rd_hold", {29'h0, m_stb, m_adr, m_we}, 32'h4);
    nrst = 1'b0;
    wait_cyc(2);
    check("reset_mid_rd", {29'h0, m_stb, m_adr, m_we}, 32'h2);
    port_q.delete(); port_refresh();
    data_ack_en = 1'b1;
    nrst = 1'b1;
    wait_cyc(10);
    check("poll_period", poll_gap, 2);
    check("rx_nothing_taken", rx_exp.size(), 0);
    read_expect("stat_after_reset", 2'd1, 8'h00);

    // Single PC byte into RX.
    port_q.push_back(8'hA5); port_refresh();
    n = 0;
    do begin wait_cyc(1); n++; end while (rx_exp.size() == 0 && n < 30);
    wait_cyc(2);
    read_expect("stat_rx_nonempty", 2'd1, 8'h01);
    bus_read(2'd0, d);
    exp = (rx_exp.size() != 0) ? {24'h0, rx_exp.pop_front()} : 32'h100;
    check("rx_byte_a5", {24'h0, d}, exp);
    check("rx_byte_value", {24'h0, d}, 32'hA5);
    read_expect("stat_rx_drained", 2'd1, 8'h00);

    // Two bytes to the PC, spaced by the data byte period.
    w0 = wr_count;
    tx_exp.push_back(8'h3C); bus_write(2'd0, 8'h3C);
    tx_exp.push_back(8'h7E); bus_write(2'd0, 8'h7E);
    n = 0;
    do begin wait_cyc(1); n++; end while (wr_count < w0 + 2 && n < 40);
    check("tx_two_writes", wr_count - w0, 2);
    check("tx_spacing", wr_gap, 3 + GAPCYC);

    // Port still holding a TX byte blocks writes.
    tx_busy = 1'b1;
    wait_cyc(4);
    tx_exp.push_back(8'h55); bus_write(2'd0, 8'h55);
    w0 = wr_count;
    wait_cyc(20);
    check("tx_blocked", wr_count - w0, 0);
    tx_busy = 1'b0;
    n = 0;
    do begin wait_cyc(1); n++; end while (wr_count == w0 && n < 8);
    check("tx_release_latency", {31'h0, n <= 4}, 32'h1);
    check("tx_release_write", wr_count - w0, 1);

    // Overflow TX: ninth byte dropped, drp set, then cleared.
    tx_busy = 1'b1;
    wait_cyc(4);
    for (int i = 0; i < DEPTH + 1; i++) begin
      d = 8'h80 + 8'(i);
      if (i < DEPTH) tx_exp.push_back(d);
      bus_write(2'd0, d);
    end
    read_expect("stat_full_drop", 2'd1, 8'h0A);
    bus_write(2'd1, 8'h08);
    read_expect("stat_drop_cleared", 2'd1, 8'h02);
    w0 = wr_count;
    tx_busy = 1'b0;
    n = 0;
    do begin wait_cyc(1); n++; end while (wr_count < w0 + DEPTH && n < 80);
    check("tx_drain_count", wr_count - w0, DEPTH);
    check("tx_scoreboard_empty", tx_exp.size(), 0);
    read_expect("stat_tx_drained", 2'd1, 8'h00);

    // Underrun on empty RX.
    read_expect("rx_underrun_data", 2'd0, 8'h00);
    read_expect("stat_underrun", 2'd1, 8'h04);
    bus_write(2'd1, 8'h04);
    read_expect("stat_urn_cleared", 2'd1, 8'h00);

    // Both directions pending: accesses must alternate, RX first after a WR.
    tx_busy = 1'b1;
    wait_cyc(4);
    for (int i = 0; i < 3; i++) begin
      tx_exp.push_back(8'hD0 + 8'(i));
      bus_write(2'd0, 8'hD0 + 8'(i));
    end
    acc_q.delete();
    port_q.push_back(8'hC1); port_q.push_back(8'hC2); port_q.push_back(8'hC3);
    port_refresh();
    tx_busy = 1'b0;
    n = 0;
    do begin wait_cyc(1); n++; end while (acc_q.size() < 6 && n < 80);
    for (int i = 0; i < 6; i++) begin
      exp = (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hFFFF_FFFF;
      check("fair_order", exp, 32'(i % 2));
    end
    wait_cyc(4);
`ifdef M_EPP_FIFO_COUNT_EN
    read_expect("rx_occupancy", 2'd2, 8'h03);
    read_expect("tx_occupancy", 2'd3, 8'h00);
`else
    read_expect("adr2_zero", 2'd2, 8'h00);
`endif
    for (int i = 0; i < 3; i++) begin
      bus_read(2'd0, d);
      exp = (rx_exp.size() != 0) ? {24'h0, rx_exp.pop_front()} : 32'h100;
      check("rx_fair_byte", {24'h0, d}, exp);
    end
    read_expect("stat_final", 2'd1, 8'h00);

`ifdef M_EPP_FIFO_COUNT_EN
    // Flush TX: pending bytes must never reach the port.
    tx_busy = 1'b1;
    wait_cyc(4);
    bus_write(2'd0, 8'hEE);
    bus_write(2'd0, 8'hEF);
    read_expect("tx_occ_two", 2'd3, 8'h02);
    bus_write(2'd3, 8'h00);
    read_expect("tx_occ_flushed", 2'd3, 8'h00);
    read_expect("stat_after_flush", 2'd1, 8'h00);
    w0 = wr_count;
    tx_busy = 1'b0;
    wait_cyc(15);
    check("tx_flush_no_write", wr_count - w0, 0);
`endif

    wait_cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
